// File: rtl/motor_pkg.sv
// Shared types for the motor drive arbiter: FSM state encoding and default duty width.
package motor_pkg;

    localparam int DUTY_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        AUTO   = 2'd2,
        DRAIN  = 2'd3
    } motor_state_e;

endpackage

// File: rtl/motor_ramp_limiter.sv
// One motor channel: walks the registered duty toward the target by at most
// RAMP_STEP per tick. force_zero drops duty to 0 immediately (emergency stop).
// Optional feature macro: MOTOR_ARB_RAMP_EN (undefined -> duty follows target
// one edge later, tick ignored).
module motor_ramp_limiter
    import motor_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int RAMP_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              force_zero,
    input  logic [DUTY_W-1:0] tgt,
    output logic [DUTY_W-1:0] duty
);

`ifdef MOTOR_ARB_RAMP_EN
    // Clamp the step so duty+step always fits in DUTY_W+1 bits.
    localparam int              STEP_I = (RAMP_STEP > (2**DUTY_W) - 1) ? (2**DUTY_W) - 1 : RAMP_STEP;
    localparam logic [DUTY_W:0] STEP   = (DUTY_W+1)'(STEP_I);

    logic [DUTY_W:0] duty_x, tgt_x, up, dn, nxt;

    assign duty_x = {1'b0, duty};
    assign tgt_x  = {1'b0, tgt};
    assign up     = duty_x + STEP;
    assign dn     = (duty_x > STEP) ? duty_x - STEP : '0;

    // Next ramp value: step toward target, clipped at the target so it never overshoots.
    always_comb begin
        nxt = duty_x;
        if (duty_x < tgt_x)
            nxt = (up > tgt_x) ? tgt_x : up;
        else if (duty_x > tgt_x)
            nxt = (dn < tgt_x) ? tgt_x : dn;
    end

    // Duty register: zero on reset/force, otherwise advance only on ramp ticks.
    always_ff @(posedge clk) begin
        if (reset)
            duty <= '0;
        else if (force_zero)
            duty <= '0;
        else if (tick)
            duty <= nxt[DUTY_W-1:0];
    end
`else
    logic        tick_unused;
    logic [31:0] step_unused;
    assign tick_unused = tick;
    assign step_unused = 32'(RAMP_STEP);

    // Duty register: plain one-cycle follower of the target.
    always_ff @(posedge clk) begin
        if (reset)
            duty <= '0;
        else if (force_zero)
            duty <= '0;
        else
            duty <= tgt;
    end
`endif

endmodule

// File: rtl/motor_drive_arbiter.sv
// Motor drive arbiter: manual/autonomous valid-ready arbitration with manual
// preemption, command watchdog, emergency stop and per-channel duty ramp.
// Optional feature macro: MOTOR_ARB_RAMP_EN (ramp divider + limiter).
module motor_drive_arbiter
    import motor_pkg::*;
#(
    parameter int DUTY_W         = DUTY_W_DEF,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int RAMP_DIV       = 256,
    parameter int RAMP_STEP      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              estop,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [DUTY_W-1:0] m_duty_l,
    input  logic [DUTY_W-1:0] m_duty_r,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DUTY_W-1:0] a_duty_l,
    input  logic [DUTY_W-1:0] a_duty_r,
    output logic [DUTY_W-1:0] duty_left,
    output logic [DUTY_W-1:0] duty_right,
    output logic [1:0]        state,
    output logic              timeout_pulse
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    motor_state_e      st;
    logic [WD_W-1:0]   wdog;
    logic [DUTY_W-1:0] tgt_l, tgt_r;
    logic              m_xfer, a_xfer, wdog_exp, tick;

    assign state    = st;
    assign m_xfer   = m_valid && m_ready;
    assign a_xfer   = a_valid && a_ready;
    assign wdog_exp = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Readies depend only on state, estop and m_valid (manual always wins a tie).
    always_comb begin
        m_ready = 1'b0;
        a_ready = 1'b0;
        if (!estop) begin
            case (st)
                IDLE, AUTO: begin
                    m_ready = 1'b1;
                    a_ready = !m_valid;
                end
                MANUAL:  m_ready = 1'b1;
                default: ;
            endcase
        end
    end

    // Ownership FSM with targets, watchdog and timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= IDLE;
            tgt_l         <= '0;
            tgt_r         <= '0;
            wdog          <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            if (estop) begin
                st    <= DRAIN;
                tgt_l <= '0;
                tgt_r <= '0;
                wdog  <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        wdog <= '0;
                        if (m_xfer) begin
                            st    <= MANUAL;
                            tgt_l <= m_duty_l;
                            tgt_r <= m_duty_r;
                        end else if (a_xfer) begin
                            st    <= AUTO;
                            tgt_l <= a_duty_l;
                            tgt_r <= a_duty_r;
                        end
                    end
                    MANUAL, AUTO: begin
                        // a_xfer can only happen in AUTO, so the branches are shared.
                        if (m_xfer) begin
                            st    <= MANUAL;
                            tgt_l <= m_duty_l;
                            tgt_r <= m_duty_r;
                            wdog  <= '0;
                        end else if (a_xfer) begin
                            tgt_l <= a_duty_l;
                            tgt_r <= a_duty_r;
                            wdog  <= '0;
                        end else if (wdog_exp) begin
                            st            <= DRAIN;
                            tgt_l         <= '0;
                            tgt_r         <= '0;
                            wdog          <= '0;
                            timeout_pulse <= 1'b1;
                        end else begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                    default: begin
                        tgt_l <= '0;
                        tgt_r <= '0;
                        wdog  <= '0;
                        if (duty_left == '0 && duty_right == '0)
                            st <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MOTOR_ARB_RAMP_EN
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_W'(RAMP_DIV - 1));

    // Free-running ramp divider; commands never resynchronise it.
    always_ff @(posedge clk) begin
        if (reset)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end
`else
    logic [31:0] div_unused;
    assign div_unused = 32'(RAMP_DIV);
    assign tick       = 1'b0;
`endif

    motor_ramp_limiter #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_ramp_l (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .force_zero (estop),
        .tgt        (tgt_l),
        .duty       (duty_left)
    );

    motor_ramp_limiter #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP)) u_ramp_r (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .force_zero (estop),
        .tgt        (tgt_r),
        .duty       (duty_right)
    );

endmodule
